mem_wb_reg: RTL

- Pipeline register and write-back selector between the MEM stage and the register file in the forwarding (redirect) pipeline CPU.
- Captures the MEM-stage ALU result, load data, destination register and control bits each cycle.
- Selects the write-back value and drives the register-file write port.
- Also supplies the MEM/WB forwarding source to EX, tracks a halt instruction through the pipe, and counts retired instructions.

---
 rtl/mem_wb_reg_pkg.sv | 30 +++
 rtl/mem_wb_reg_if.sv | 50 +++++
 rtl/mem_wb_reg_fwd_cmp.sv | 21 ++
 rtl/mem_wb_reg.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_wb_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_reg_pkg
//  Purpose  : Shared constants and types for the MEM/WB pipeline register:
//             the $zero register number, the MEM-stage control bundle and
//             the halt FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package mem_wb_reg_pkg;

    // Register number of the hard-wired zero register; never written.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control bundle produced by the MEM stage (9 bits).
    typedef struct packed {
        logic       rw_en;
        logic       lh;
        logic       memread;
        logic       memw;
        logic [4:0] rW;
    } mem_ctrl_t;

    // Halt tracking state.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_e;

endpackage : mem_wb_reg_pkg
`default_nettype wire

// File: rtl/mem_wb_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_if
//  Purpose  : Bundle of MEM-side inputs and WB/forwarding/status outputs of
//             the MEM/WB pipeline register. The master drives the pipeline
//             side, the slave is the register itself.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_wb_if #(
    parameter int DW = 32,
    parameter int CW = 32
);
    logic          stall;
    logic          flush;
    logic          valid_in;
    logic [DW-1:0] result;
    logic [DW-1:0] mem_v;
    logic          rw_en;
    logic          memread;
    logic [4:0]    rW;
    logic          halt_in;
    logic          resume;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;

    logic [DW-1:0] wb_data;
    logic [4:0]    wb_rW;
    logic          wb_we;
    logic          fwd_a;
    logic          fwd_b;
    logic          halted;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] load_cnt;

    modport master (
        output stall, flush, valid_in, result, mem_v, rw_en, memread, rW,
               halt_in, resume, ex_rs, ex_rt,
        input  wb_data, wb_rW, wb_we, fwd_a, fwd_b, halted,
               retired_cnt, load_cnt
    );

    modport slave (
        input  stall, flush, valid_in, result, mem_v, rw_en, memread, rW,
               halt_in, resume, ex_rs, ex_rt,
        output wb_data, wb_rW, wb_we, fwd_a, fwd_b, halted,
               retired_cnt, load_cnt
    );

endinterface : mem_wb_if
`default_nettype wire

// File: rtl/mem_wb_reg_fwd_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_cmp
//  Purpose  : Register-number comparator for MEM/WB forwarding. Flags a match
//             only when the WB write is enabled and the destination is not
//             the zero register.
//  Revision : 1.0  initial release
// ============================================================================
import mem_wb_reg_pkg::*;

module fwd_cmp (
    input  wire logic       we_i,
    input  wire logic [4:0] dst_i,
    input  wire logic [4:0] src_i,
    output logic            match_o
);

    assign match_o = we_i && (dst_i != REG_ZERO) && (dst_i == src_i);

endmodule : fwd_cmp
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_reg
//  Purpose  : MEM/WB pipeline register with write-back select, MEM/WB
//             forwarding detect, halt tracking and retirement statistics.
//             Optional macro MEMWB_STATS_EN enables the retired/load
//             counters; without it both counter ports read as zero.
//  Revision : 1.0  initial release
// ============================================================================
import mem_wb_reg_pkg::*;

module mem_wb_reg #(
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_wb_if.slave   bus
);

    // Pipeline fields
    logic          valid_q,   valid_d;
    logic          rw_en_q,   rw_en_d;
    logic          memread_q, memread_d;
    logic [4:0]    rw_q,      rw_d;
    logic [DW-1:0] result_q,  result_d;
    logic [DW-1:0] mem_v_q,   mem_v_d;

    halt_state_e   state_q;

    logic          w_capture;
    logic          w_wb_we;

    // A real capture happens only in RUN with neither stall nor flush.
    assign w_capture = !bus.flush && !bus.stall && (state_q == RUN);

    // Next-state select: flush (or HALTED without stall) loads a bubble,
    // stall holds, otherwise capture the MEM stage.
    always_comb begin
        valid_d   = valid_q;
        rw_en_d   = rw_en_q;
        memread_d = memread_q;
        rw_d      = rw_q;
        result_d  = result_q;
        mem_v_d   = mem_v_q;
        if (bus.flush || (!bus.stall && (state_q == HALTED))) begin
            valid_d   = 1'b0;
            rw_en_d   = 1'b0;
            memread_d = 1'b0;
            rw_d      = REG_ZERO;
            result_d  = '0;
            mem_v_d   = '0;
        end else if (!bus.stall) begin
            valid_d   = bus.valid_in;
            rw_en_d   = bus.rw_en;
            memread_d = bus.memread;
            rw_d      = bus.rW;
            result_d  = bus.result;
            mem_v_d   = bus.mem_v;
        end
    end

    // Pipeline register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rw_en_q   <= 1'b0;
            memread_q <= 1'b0;
            rw_q      <= REG_ZERO;
            result_q  <= '0;
            mem_v_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rw_en_q   <= rw_en_d;
            memread_q <= memread_d;
            rw_q      <= rw_d;
            result_q  <= result_d;
            mem_v_q   <= mem_v_d;
        end
    end

    // Halt FSM: a captured halt instruction wins over a same-edge resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_capture && bus.valid_in && bus.halt_in) begin
                        state_q <= HALTED;
                    end
                end
                HALTED: begin
                    if (bus.resume) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Write-back select and register-file port.
    assign w_wb_we     = rw_en_q && valid_q && (rw_q != REG_ZERO);
    assign bus.wb_data = memread_q ? mem_v_q : result_q;
    assign bus.wb_rW   = rw_q;
    assign bus.wb_we   = w_wb_we;
    assign bus.halted  = (state_q == HALTED);

    fwd_cmp u_fwd_a (
        .we_i    (w_wb_we),
        .dst_i   (rw_q),
        .src_i   (bus.ex_rs),
        .match_o (bus.fwd_a)
    );

    fwd_cmp u_fwd_b (
        .we_i    (w_wb_we),
        .dst_i   (rw_q),
        .src_i   (bus.ex_rt),
        .match_o (bus.fwd_b)
    );

`ifdef MEMWB_STATS_EN
    logic [CW-1:0] retired_q;
    logic [CW-1:0] load_q;
    logic          w_retire;

    assign w_retire = w_capture && bus.valid_in;

    // Retirement statistics; wrap naturally at 2^CW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            load_q    <= '0;
        end else if (w_retire) begin
            retired_q <= retired_q + CW'(1);
            if (bus.memread) begin
                load_q <= load_q + CW'(1);
            end
        end
    end

    assign bus.retired_cnt = retired_q;
    assign bus.load_cnt    = load_q;
`else
    assign bus.retired_cnt = {CW{1'b0}};
    assign bus.load_cnt    = {CW{1'b0}};
`endif

endmodule : mem_wb_reg
`default_nettype wire
